// File: rtl/min_scan_ctrl.sv
// Frame-minimum scanner: loads a 16-beat frame, scans it one element per cycle,
// and presents the smallest, second-smallest and lowest index of the smallest.
//
// state  | meaning
// S_LOAD | accepting beats into element registers
// S_SCAN | walking elements 0..15, tracking running minima
// S_DONE | result valid, waiting for out_ready
module min_scan_ctrl #(
  parameter int N_ELEM = 16,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] min1,
  output logic [DATA_W-1:0] min2,
  output logic [3:0]        index_min1,
  output logic              busy
);

  localparam logic [3:0] LAST_IDX = 4'(N_ELEM - 1);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] elem_q [N_ELEM];
  logic [DATA_W-1:0] m1_q, m1_d;
  logic [DATA_W-1:0] m2_q, m2_d;
  logic [3:0]        idx_q, idx_d;
  logic [DATA_W-1:0] min1_q, min1_d;
  logic [DATA_W-1:0] min2_q, min2_d;
  logic [3:0]        imin_q, imin_d;
  logic [DATA_W-1:0] cur_v;
  logic              accept;

  assign accept = (state_q == S_LOAD) && in_valid && !flush;
  assign cur_v  = elem_q[cnt_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m1_d    = m1_q;
    m2_d    = m2_q;
    idx_d   = idx_q;
    min1_d  = min1_q;
    min2_d  = min2_q;
    imin_d  = imin_q;
    case (state_q)
      S_LOAD: begin
        if (accept) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == LAST_IDX) begin
            state_d = S_SCAN;
            cnt_d   = '0;
            m1_d    = '1;
            m2_d    = '1;
            idx_d   = '0;
          end
        end
      end
      S_SCAN: begin
        // strict less-than keeps the earliest index on ties and lets m2 equal m1
        if (cur_v < m1_q) begin
          m2_d  = m1_q;
          m1_d  = cur_v;
          idx_d = cnt_q;
        end else if (cur_v < m2_q) begin
          m2_d = cur_v;
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_IDX) begin
          state_d = S_DONE;
          cnt_d   = '0;
          min1_d  = m1_d;
          min2_d  = m2_d;
          imin_d  = idx_d;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase
    // abort wins over everything, including a scan finishing on this edge
    if (flush) begin
      state_d = S_LOAD;
      cnt_d   = '0;
      min1_d  = min1_q;
      min2_d  = min2_q;
      imin_d  = imin_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      m1_q    <= '0;
      m2_q    <= '0;
      idx_q   <= '0;
      min1_q  <= '0;
      min2_q  <= '0;
      imin_q  <= '0;
      for (int k = 0; k < N_ELEM; k++) elem_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m1_q    <= m1_d;
      m2_q    <= m2_d;
      idx_q   <= idx_d;
      min1_q  <= min1_d;
      min2_q  <= min2_d;
      imin_q  <= imin_d;
      if (accept) elem_q[cnt_q] <= in_data;
    end
  end

  assign in_ready   = (state_q == S_LOAD);
  assign busy       = (state_q == S_SCAN);
  assign out_valid  = (state_q == S_DONE);
  assign min1       = min1_q;
  assign min2       = min2_q;
  assign index_min1 = imin_q;

endmodule

// File: tb/tb_min_scan_ctrl.sv
// Randomized scoreboard bench for min_scan_ctrl against a sort-based reference.
module tb_min_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic       out_ready = 1'b1;
  logic       in_ready, out_valid, busy;
  logic [3:0] min1, min2, index_min1;

  min_scan_ctrl #(.N_ELEM(16), .DATA_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .min1(min1), .min2(min2), .index_min1(index_min1), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef logic [3:0] frame_t [16];
  typedef struct {
    logic [3:0] m1;
    logic [3:0] m2;
    logic [3:0] idx;
    longint     acc;
  } exp_t;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  exp_t   sb[$];
  bit     mon_en = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  // min1/min2 are the first two entries of the sorted multiset
  function automatic exp_t ref_model(input frame_t f);
    exp_t e;
    int   s[$];
    foreach (f[k]) s.push_back(int'(f[k]));
    s.sort();
    e.m1  = 4'(s[0]);
    e.m2  = 4'(s[1]);
    e.idx = 4'd0;
    for (int k = 15; k >= 0; k--) if (f[k] == e.m1) e.idx = 4'(k);
    e.acc = 0;
    return e;
  endfunction

  function automatic frame_t mk(input int a, b, c, d, e, g, fill);
    frame_t f;
    for (int k = 0; k < 16; k++) f[k] = 4'(fill);
    f[0] = 4'(a); f[1] = 4'(b); f[2] = 4'(c);
    f[3] = 4'(d); f[4] = 4'(e); f[5] = 4'(g);
    return f;
  endfunction

  function automatic frame_t rnd_frame();
    frame_t f;
    for (int k = 0; k < 16; k++)
      f[k] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
    return f;
  endfunction

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic put_beat(input logic [3:0] v);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clk);
    while (!in_ready && guard < 200) begin @(negedge clk); guard++; end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_beats(input frame_t f, input int n, input int gap_pct);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 99) < gap_pct) idle($urandom_range(1, 3));
      put_beat(f[k]);
    end
  endtask

  task automatic send_frame(input frame_t f, input int gap_pct);
    exp_t e;
    send_beats(f, 16, gap_pct);
    e = ref_model(f);
    e.acc = cyc;
    sb.push_back(e);
  endtask

  task automatic flush_cycle();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'd0;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int guard = 0;
    @(negedge clk);
    while (!out_valid && guard < 100) begin @(negedge clk); guard++; end
    if (!out_valid) chk("wait_valid_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int guard = 0;
    while ((sb.size() != 0 || out_valid || busy) && guard < 2000) begin
      @(posedge clk); #1; guard++;
    end
    chk("drain_sb_empty", sb.size(), 0);
  endtask

  // Monitor: pops on each rising out_valid, checks handshake and result hold
  logic       pv = 1'b0, p_ord = 1'b0, p_fl = 1'b0, p_rst = 1'b0;
  logic [3:0] lm1 = 4'd0, lm2 = 4'd0, lidx = 4'd0;
  exp_t       cur;

  always @(negedge clk) begin
    if (mon_en) begin
      if (!p_rst) begin
        lm1 = 4'd0; lm2 = 4'd0; lidx = 4'd0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_result", {min1, min2, index_min1}, 12'h000);
      end else begin
        if (out_valid && !pv) begin
          if (sb.size() == 0) begin
            chk("unexpected_result", 1, 0);
          end else begin
            cur = sb.pop_front();
            chk("latency", int'(cyc - cur.acc), 16);
            chk("min1", min1, cur.m1);
            chk("min2", min2, cur.m2);
            chk("index_min1", index_min1, cur.idx);
            lm1 = cur.m1; lm2 = cur.m2; lidx = cur.idx;
          end
        end
        if (pv && (p_ord || p_fl)) chk("valid_drop", out_valid, 0);
        else if (pv)               chk("valid_hold", out_valid, 1);
        chk("result_hold", {min1, min2, index_min1}, {lm1, lm2, lidx});
        chk("in_ready_decode", in_ready, int'(!(busy || out_valid)));
        chk("busy_valid_excl", busy & out_valid, 0);
      end
    end
    pv    = out_valid;
    p_ord = out_ready;
    p_fl  = flush;
    p_rst = rst_n;
  end

  initial begin
    frame_t f;
    @(posedge clk); #1;
    mon_en = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;

    // basic, tie, gapped frame with stalled consumer
    send_frame(mk(2, 3, 1, 2, 5, 6, 9), 0);
    drain();
    send_frame(mk(1, 4, 2, 1, 2, 12, 9), 0);
    drain();
    out_ready = 1'b0;
    send_frame(mk(5, 2, 10, 0, 4, 1, 9), 40);
    wait_valid();
    repeat (4) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    drain();

    // flush mid-load, then complete frames (all-15 and random)
    for (int r = 0; r < 2; r++) begin
      f = rnd_frame();
      send_beats(f, 7 - 2 * r, 0);
      flush_cycle();
      if (r == 0) send_frame(mk(15, 15, 15, 15, 15, 15, 15), 0);
      else        send_frame(rnd_frame(), 10);
      drain();
    end

    // flush during scan discards the frame
    send_frame(rnd_frame(), 0);
    idle(5);
    flush_cycle();
    void'(sb.pop_back());
    idle(25);

    // flush in DONE while consumer stalled
    out_ready = 1'b0;
    send_frame(rnd_frame(), 0);
    wait_valid();
    idle(2);
    flush_cycle();
    out_ready = 1'b1;
    idle(5);

    // reset during scan cycle 8, then all-zero frame
    send_frame(rnd_frame(), 0);
    idle(7);
    rst_n = 1'b0;
    void'(sb.pop_back());
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(25);
    send_frame(mk(0, 0, 0, 0, 0, 0, 0), 0);
    drain();

    // back-to-back random frames, consumer always ready
    for (int r = 0; r < 20; r++) send_frame(rnd_frame(), 20);
    drain();

    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/min_scan_ctrl.md
MIN_SCAN_CTRL -- requirements
Module: min_scan_ctrl

Interface
REQ-001 Parameter N_ELEM, 16, number of elements per frame (fixed; index width 4).
REQ-002 Parameter DATA_W, 4, element width in bits (fixed).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 flush  input  1  synchronous soft abort of current frame.
REQ-006 in_valid  input  1  in_data beat offered.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 in_data  input  4  element value, unsigned.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 min1  output  4  smallest element of last completed frame.
REQ-012 min2  output  4  second element of sorted frame multiset (equals min1 when min1 duplicated).
REQ-013 index_min1  output  4  lowest index holding min1.
REQ-014 busy  output  1  high while in SCAN.

Function
REQ-015 FSM states SHALL be LOAD, SCAN, DONE; all outputs registered or decoded from state only.
REQ-016 LOAD: in_ready=1; beat accepted on edge with in_valid&in_ready; beat k (0..15, arrival order) stored to element register k; 4-bit beat counter increments per accepted beat; gaps in in_valid allowed.
REQ-017 LOAD->SCAN on the edge accepting beat 15; counter wraps to 0; running m1=4'hF, m2=4'hF, idx=0 initialised on same edge.
REQ-018 SCAN: in_ready=0, busy=1; one element per cycle, index i=0..15, 16 cycles total.
REQ-019 Scan update: if v<m1 then m2<=m1, m1<=v, idx<=i; else if v<m2 then m2<=v; else no change (ties to m1 keep lower idx, may set m2=m1).
REQ-020 SCAN->DONE on edge processing i=15; min1/min2/index_min1 loaded from final m1/m2/idx (including element 15 update) on that edge; out_valid=1 from next cycle.
REQ-021 Latency: out_valid rises exactly 16 cycles after the edge accepting beat 15.
REQ-022 DONE: out_valid held high, result outputs stable, in_ready=0, until out_ready=1; on that edge out_valid<=0, state->LOAD.
REQ-023 Result outputs SHALL hold last result through LOAD and SCAN; changed only on SCAN->DONE edge.
REQ-024 flush=1 in any state: next state LOAD, beat counter 0, out_valid 0, busy 0; result outputs unchanged; in_data beat in flush cycle dropped.
REQ-025 flush and out_ready both high in DONE: flush behaviour applies (same resulting state).
REQ-026 All comparisons unsigned 4-bit; no arithmetic overflow possible; all-15 frame gives min1=15, min2=15, index_min1=0.

Reset
REQ-027 rst_n=0 sampled at edge: state LOAD, counter 0, out_valid 0, busy 0, min1=0, min2=0, index_min1=0, element registers 0; in_ready=1 from first cycle after release.
REQ-028 rst_n=0 overrides flush and all handshakes; reset mid-LOAD/SCAN/DONE discards the frame, no result emitted.

Verification
REQ-029 Frame {2,3,1,2,5,6,9x10}, out_ready=1 -> min1=1, min2=2, index_min1=2; out_valid exactly 16 cycles after last beat, for 1 cycle.
REQ-030 Frame {1,4,2,1,2,12,9x10} -> min1=1, min2=1, index_min1=0 (tie keeps lowest index).
REQ-031 Frame {5,2,10,0,4,1,9x10} with random in_valid gaps, out_ready low 5 cycles -> min1=0, min2=1, index_min1=3; outputs stable, in_ready=0 while waiting.
REQ-032 Flush after 7 beats, then full frame {15x16} -> only one result: min1=15, min2=15, index_min1=0.
REQ-033 rst_n low during SCAN cycle 8 -> out_valid never rises, outputs 0, in_ready=1 after release; next frame {0x16} -> min1=0, min2=0, index_min1=0.
REQ-034 Back-to-back frames with out_ready tied high -> in_ready=0 during SCAN/DONE, no beat lost, each result matches a software reference model.
